// File: rtl/uart_frame_rx_if.sv
// Word stream from the UART 8-to-16 converter into the frame receiver.
interface uart_frame_rx_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] data_in;
   logic              data_valid;

   modport master (output data_in, output data_valid);
   modport slave  (input  data_in, input  data_valid);
endinterface

// File: rtl/uart_frame_rx.sv
// Frame receiver: sync hunt, 5-word payload, XOR check, atomic output update, link timeout.
// Optional macro FRAME_SYNC_RESTART_EN: a sync word mid-frame aborts and restarts the frame.
module uart_frame_rx #(
   parameter logic [15:0] SYNC_WORD      = 16'hA55A,
   parameter int          TIMEOUT_CYCLES = 6_500_000
) (
   input  logic           clk,
   input  logic           rst,
   uart_frame_rx_if.slave rx,
   output logic [11:0]    pl2_posx,
   output logic [11:0]    pl2_posy,
   output logic [11:0]    ball_posx,
   output logic [11:0]    ball_posy,
   output logic [3:0]     pl1_score,
   output logic [3:0]     pl2_score,
   output logic           flag_point,
   output logic           end_game,
   output logic           whistle,
   output logic           frame_ok,
   output logic           frame_err,
   output logic           link_up,
   output logic [7:0]     err_cnt
);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

   localparam logic [22:0] TO_PRE = 23'(TIMEOUT_CYCLES - 2);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [22:0] sat_inc23(input logic [22:0] v);
      return (v == '1) ? v : v + 23'd1;
   endfunction

   state_t      state, state_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [15:0] acc, acc_nxt;
   logic [15:0] word;
   logic        sync_restart;
   logic        shadow_we;
   logic        ok_nxt, err_nxt;
   logic        ok_p0, err_p0;
   logic [11:0] sh_pos [4];
   logic [10:0] sh_ctl;
   logic [22:0] to_cnt;
   logic        to_half;
   logic        timeout;

   assign word = rx.data_in;

`ifdef FRAME_SYNC_RESTART_EN
   assign sync_restart = (word == SYNC_WORD);
`else
   assign sync_restart = 1'b0;
`endif

   // A publish on the same edge as the timeout takes precedence.
   assign timeout = !ok_p0 && to_half && (to_cnt == TO_PRE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= HUNT;
         idx    <= '0;
         acc    <= '0;
         ok_p0  <= 1'b0;
         err_p0 <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         acc    <= acc_nxt;
         ok_p0  <= ok_nxt;
         err_p0 <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      acc_nxt   = acc;
      shadow_we = 1'b0;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      if (timeout) begin
         state_nxt = HUNT;
      end else if (rx.data_valid) begin
         case (state)
            HUNT: begin
               if (word == SYNC_WORD) begin
                  state_nxt = PAYLOAD;
                  idx_nxt   = '0;
                  acc_nxt   = '0;
               end
            end
            PAYLOAD: begin
               if (sync_restart) begin
                  err_nxt = 1'b1;
                  idx_nxt = '0;
                  acc_nxt = '0;
               end else begin
                  shadow_we = 1'b1;
                  acc_nxt   = acc ^ word;
                  if (idx == 3'd4) state_nxt = CHECK;
                  else             idx_nxt   = idx + 3'd1;
               end
            end
            CHECK: begin
               if (sync_restart) begin
                  err_nxt   = 1'b1;
                  state_nxt = PAYLOAD;
                  idx_nxt   = '0;
                  acc_nxt   = '0;
               end else begin
                  ok_nxt    = (word == acc);
                  err_nxt   = (word != acc);
                  state_nxt = HUNT;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   // Shadow holds the frame being collected; outputs only copy it once the checksum passes.
   always_ff @(posedge clk) begin
      if (shadow_we) begin
         if (idx == 3'd4) sh_ctl           <= {word[15:8], word[2:0]};
         else             sh_pos[idx[1:0]] <= word[11:0];
      end
   end

   // ---- p0 -> output stage: publish one edge after the checksum is sampled ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pl2_posx   <= 12'd974;
         pl2_posy   <= 12'd679;
         ball_posx  <= '0;
         ball_posy  <= '0;
         pl1_score  <= '0;
         pl2_score  <= '0;
         flag_point <= 1'b0;
         end_game   <= 1'b0;
         whistle    <= 1'b0;
         frame_ok   <= 1'b0;
         frame_err  <= 1'b0;
         link_up    <= 1'b0;
         err_cnt    <= '0;
      end else begin
         frame_ok  <= ok_p0;
         frame_err <= err_p0;
         if (ok_p0) begin
            pl2_posx   <= sh_pos[0];
            pl2_posy   <= sh_pos[1];
            ball_posx  <= sh_pos[2];
            ball_posy  <= sh_pos[3];
            pl1_score  <= sh_ctl[10:7];
            pl2_score  <= sh_ctl[6:3];
            flag_point <= sh_ctl[2];
            end_game   <= sh_ctl[1];
            whistle    <= sh_ctl[0];
            link_up    <= 1'b1;
         end else if (timeout) begin
            link_up <= 1'b0;
         end
         if (err_p0) err_cnt <= sat_inc8(err_cnt);
      end
   end

   // Timeout counter advances on every second cycle and restarts on each publish.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt  <= '0;
         to_half <= 1'b0;
      end else if (ok_p0) begin
         to_cnt  <= '0;
         to_half <= 1'b0;
      end else begin
         to_half <= ~to_half;
         if (to_half) to_cnt <= sat_inc23(to_cnt);
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx with a shortened link timeout.
module tb_uart_frame_rx;
   localparam int          TO   = 100;
   localparam logic [15:0] SYNC = 16'hA55A;

   typedef struct {
      bit          ok;
      logic [11:0] px, py, bx, by;
      logic [3:0]  s1, s2;
      logic        fp, eg, wh;
      logic [7:0]  err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [11:0] pl2_posx, pl2_posy, ball_posx, ball_posy;
   logic [3:0]  pl1_score, pl2_score;
   logic        flag_point, end_game, whistle, frame_ok, frame_err, link_up;
   logic [7:0]  err_cnt;

   exp_t q[$];
   exp_t cur;
   int   vec_cnt = 0;
   int   miscmp  = 0;

   always #5 clk = ~clk;

   uart_frame_rx_if #(.DATA_W(16)) rx_if ();

   uart_frame_rx #(.SYNC_WORD(SYNC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rx(rx_if),
      .pl2_posx(pl2_posx), .pl2_posy(pl2_posy),
      .ball_posx(ball_posx), .ball_posy(ball_posy),
      .pl1_score(pl1_score), .pl2_score(pl2_score),
      .flag_point(flag_point), .end_game(end_game), .whistle(whistle),
      .frame_ok(frame_ok), .frame_err(frame_err),
      .link_up(link_up), .err_cnt(err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sat8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   task automatic reset_model();
      cur = '{ok: 1'b0, px: 12'd974, py: 12'd679, bx: 12'd0, by: 12'd0,
              s1: 4'd0, s2: 4'd0, fp: 1'b0, eg: 1'b0, wh: 1'b0, err: 8'd0};
   endtask

   task automatic check_fields(input string pfx);
      check({pfx, "_posx"},  pl2_posx,  cur.px);
      check({pfx, "_posy"},  pl2_posy,  cur.py);
      check({pfx, "_ballx"}, ball_posx, cur.bx);
      check({pfx, "_bally"}, ball_posy, cur.by);
      check({pfx, "_score"}, {pl1_score, pl2_score}, {cur.s1, cur.s2});
      check({pfx, "_flags"}, {flag_point, end_game, whistle}, {cur.fp, cur.eg, cur.wh});
   endtask

   task automatic check_reset();
      reset_model();
      check_fields("rst");
      check("rst_pulses", {frame_ok, frame_err}, 2'b00);
      check("rst_link",   link_up, 1'b0);
      check("rst_errcnt", err_cnt, 8'd0);
   endtask

   task automatic score(input exp_t e);
      check("ok_pulse",  frame_ok,  e.ok);
      check("err_pulse", frame_err, !e.ok);
      check("err_cnt",   err_cnt,   e.err);
      check("o_posx",  pl2_posx,  e.px);
      check("o_posy",  pl2_posy,  e.py);
      check("o_ballx", ball_posx, e.bx);
      check("o_bally", ball_posy, e.by);
      check("o_score", {pl1_score, pl2_score}, {e.s1, e.s2});
      check("o_flags", {flag_point, end_game, whistle}, {e.fp, e.eg, e.wh});
      if (e.ok) check("o_link", link_up, 1'b1);
   endtask

   always @(negedge clk) begin
      if (rst && (frame_ok || frame_err)) begin
         if (q.size() == 0) check("unexpected_pulse", {frame_ok, frame_err}, 2'b00);
         else score(q.pop_front());
      end
   end

   task automatic put(input logic [15:0] w);
      rx_if.data_in    = w;
      rx_if.data_valid = 1'b1;
      @(posedge clk); #1;
      rx_if.data_valid = 1'b0;
      rx_if.data_in    = 16'h0000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_err();
      exp_t e;
      cur.err = sat8(cur.err);
      e = cur;
      e.ok = 1'b0;
      q.push_back(e);
   endtask

   task automatic send_frame(input logic [11:0] px, py, bx, by, input logic [3:0] s1, s2,
                             input logic fp, eg, wh, input logic [3:0] junk, input bit bad);
      logic [15:0] w [5];
      logic [15:0] cs;
      exp_t e;
      w[0] = {junk, px};
      w[1] = {junk, py};
      w[2] = {junk, bx};
      w[3] = {junk, by};
      w[4] = {s1, s2, 5'b0, fp, eg, wh};
      cs = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4];
      if (bad) cs = cs ^ 16'h0001;
      put(SYNC);
      for (int i = 0; i < 5; i++) put(w[i]);
      if (bad) begin
         push_err();
      end else begin
         cur.px = px; cur.py = py; cur.bx = bx; cur.by = by;
         cur.s1 = s1; cur.s2 = s2; cur.fp = fp; cur.eg = eg; cur.wh = wh;
         e = cur;
         e.ok = 1'b1;
         q.push_back(e);
      end
      put(cs);
   endtask

   initial begin
      rst = 1'b0;
      rx_if.data_valid = 1'b0;
      rx_if.data_in    = 16'h0000;
      idle(3);
      check_reset();
      rst = 1'b1;
      idle(2);

      // Reference frame, then the same frame with a corrupted checksum.
      send_frame(12'd974, 12'd679, 12'd512, 12'd256, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      idle(3);
      check("link_after_ok", link_up, 1'b1);
      send_frame(12'd974, 12'd679, 12'd512, 12'd256, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
      idle(3);
      check("errcnt_one", err_cnt, 8'd1);
      send_frame(12'd100, 12'd200, 12'd300, 12'd400, 4'd9, 4'd15, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0);

      // Garbage ahead of sync is dropped silently.
      put(16'h1234);
      put(16'hFFFF);
      send_frame(12'hFFF, 12'h001, 12'h800, 12'h7FF, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0);
      idle(3);
      check("garbage_errcnt", err_cnt, 8'd1);

      // Sync word appearing inside a frame.
      put(SYNC); put(16'h0111); put(16'h0222);
`ifdef FRAME_SYNC_RESTART_EN
      push_err();
      send_frame(12'd974, 12'd679, 12'd512, 12'd256, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
`else
      push_err();
      put(SYNC); put(16'h03CE); put(16'h02A7); put(16'h0200);
      put(16'h0100); put(16'h5304); put(16'h516D);
`endif
      idle(3);

      // Link timeout after a good frame; outputs keep the last frame.
      send_frame(12'd11, 12'd22, 12'd33, 12'd44, 4'd6, 4'd7, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      @(posedge clk);
      repeat (2 * (TO - 1) - 1) @(posedge clk);
      #1;
      check("link_before_to", link_up, 1'b1);
      idle(1);
      check("link_at_to", link_up, 1'b0);
      check_fields("hold");

      // Partial frame abandoned by the timeout; its tail must not produce pulses.
      send_frame(12'd55, 12'd66, 12'd77, 12'd88, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      idle(2);
      put(SYNC); put(16'h0123); put(16'h0456);
      idle(2 * TO + 20);
      check("link_partial_to", link_up, 1'b0);
      put(16'h0789); put(16'h0ABC); put(16'h1200);
      put(16'h0123 ^ 16'h0456 ^ 16'h0789 ^ 16'h0ABC ^ 16'h1200);
      idle(3);
      check("partial_pending", q.size(), 0);
      check_fields("partial_hold");
      send_frame(12'd3, 12'd4, 12'd5, 12'd6, 4'd8, 4'd8, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
      idle(3);
      check("link_recover", link_up, 1'b1);

      // Error counter saturation; good frames interleaved keep the link alive.
      for (int b = 0; b < 26; b++) begin
         for (int k = 0; k < 10; k++)
            send_frame(12'(k), 12'(b), 12'd1, 12'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
         send_frame(12'(b), 12'(b + 1), 12'd9, 12'd8, 4'd2, 4'd1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      end
      idle(3);
      check("err_sat", err_cnt, 8'd255);

      // Reset in the middle of a frame.
      put(SYNC); put(16'h0001); put(16'h0002);
      rst = 1'b0;
      idle(1);
      check_reset();
      rst = 1'b1;
      idle(2);
      send_frame(12'd321, 12'd654, 12'd987, 12'd123, 4'd4, 4'd2, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0);
      idle(5);
      check("final_pending", q.size(), 0);
      check("final_errcnt", err_cnt, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
